seq_mult_shift_add: RTL and testbench

Parametrised sequential shift-add multiplier with a multiplicand register, a multiplier shift register, an accumulator and an iteration counter. It is the generalised successor of the fixed 4x4 START-triggered multiplier. It adds a configurable width, optional two's-complement mode, valid/ready handshakes on operand and result, and a held result with backpressure. It sits between an operand source and a result consumer in the datapath test designs.

---
 rtl/seq_mult_shift_add.sv | 96 +++++++++
 tb/tb_seq_mult_shift_add.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier with valid/ready operand and result handshakes.
// Signed operands are multiplied as magnitudes; the sign is reapplied on the final iteration.
module seq_mult_shift_add #(
  parameter  int WIDTH     = 4,
  parameter  bit SIGNED_EN = 1'b1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, mr, mcand;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               sgn_cap;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   nxt_acc, nxt_mr;
  logic [2*WIDTH-1:0] full, prod_nxt;
  logic               last;

  assign sgn_cap = signed_mode & SIGNED_EN;
  assign a_mag   = (sgn_cap && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag   = (sgn_cap && b_in[WIDTH-1]) ? -b_in : b_in;

  // The carry out of the add shifts into the accumulator MSB.
  assign sum      = {1'b0, acc} + (mr[0] ? {1'b0, mcand} : '0);
  assign nxt_acc  = sum[WIDTH:1];
  assign nxt_mr   = {sum[0], mr[WIDTH-1:1]};
  assign full     = {nxt_acc, nxt_mr};
  assign prod_nxt = neg ? -full : full;
  assign last     = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      mr      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand <= a_mag;
          mr    <= b_mag;
          neg   <= sgn_cap & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc <= nxt_acc;
          mr  <= nxt_mr;
          cnt <= cnt + CW'(1);
          if (last) product <= prod_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench: three multiplier instances (4-bit signed, 4-bit unsigned-only, 8-bit signed)
// checked against an integer-arithmetic product model.
`timescale 1ns/1ps
module tb_seq_mult_shift_add;

  localparam int WD  [3] = '{4, 4, 8};
  localparam bit SEN [3] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, busy, sm;
  logic [7:0]  a_in [3];
  logic [7:0]  b_in [3];
  logic [7:0]  p0, p1;
  logic [15:0] p2;

  int          checks = 0, errors = 0, cyc = 0;
  int          acc_cyc [3];
  logic [2:0]  prev_ov = '0;
  logic [15:0] q0[$], q1[$], q2[$];
  bit          rnd_bp = 1'b0;

  seq_mult_shift_add #(.WIDTH(4), .SIGNED_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_in(a_in[0][3:0]), .b_in(b_in[0][3:0]), .signed_mode(sm[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(p0), .busy(busy[0]));
  seq_mult_shift_add #(.WIDTH(4), .SIGNED_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_in(a_in[1][3:0]), .b_in(b_in[1][3:0]), .signed_mode(sm[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(p1), .busy(busy[1]));
  seq_mult_shift_add #(.WIDTH(8), .SIGNED_EN(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_in(a_in[2]), .b_in(b_in[2]), .signed_mode(sm[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .product(p2), .busy(busy[2]));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer product, wrapped to 2*w bits.
  function automatic logic [15:0] model(int w, logic [7:0] a, logic [7:0] b, bit s);
    longint ai, bi, p, lim;
    ai  = longint'(a);
    bi  = longint'(b);
    lim = longint'(1) << (w - 1);
    if (s) begin
      if (ai >= lim) ai = ai - 2 * lim;
      if (bi >= lim) bi = bi - 2 * lim;
    end
    p = (ai * bi) & ((longint'(1) << (2 * w)) - 1);
    return p[15:0];
  endfunction

  function automatic logic [15:0] get_prod(int d);
    case (d)
      0:       return {8'h00, p0};
      1:       return {8'h00, p1};
      default: return p2;
    endcase
  endfunction

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [15:0] qfront(int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(int d);
    case (d)
      0:       q0.delete(0);
      1:       q1.delete(0);
      default: q2.delete(0);
    endcase
  endtask

  task automatic push_exp(int d, logic [15:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle a result is presented it must equal the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d]) begin
          checks++;
          if (qsize(d) == 0) begin
            errors++;
            $display("FAIL unexpected_out dut%0d product=%0h", d, get_prod(d));
          end else begin
            if (get_prod(d) !== qfront(d)) begin
              errors++;
              $display("FAIL product dut%0d actual=%0h expected=%0h", d, get_prod(d), qfront(d));
            end
            if (out_ready[d]) qpop(d);
          end
          if (!prev_ov[d]) begin
            checks++;
            if (cyc - acc_cyc[d] != WD[d] + 1) begin
              errors++;
              $display("FAIL latency dut%0d actual=%0d expected=%0d", d, cyc - acc_cyc[d] - 1, WD[d]);
            end
          end
        end
        prev_ov[d] = out_valid[d];
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_bp) out_ready[2] = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(int d, logic [7:0] a, logic [7:0] b, bit s);
    int t;
    logic [7:0] m;
    m = 8'((1 << WD[d]) - 1);
    t = 0;
    @(negedge clk);
    while (!in_ready[d] && t < 300) begin @(negedge clk); t++; end
    if (!in_ready[d]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d actual=busy expected=ready", d);
      return;
    end
    in_valid[d] = 1'b1; a_in[d] = a & m; b_in[d] = b & m; sm[d] = s;
    push_exp(d, model(WD[d], a & m, b & m, s && SEN[d]));
    acc_cyc[d] = cyc;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_drain(int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 400) begin @(negedge clk); t++; end
    chk($sformatf("drain_dut%0d", d), qsize(d), 0);
  endtask

  task automatic wait_ov(int d);
    int t;
    t = 0;
    while (!out_valid[d] && t < 100) begin @(negedge clk); t++; end
    chk($sformatf("ov_timeout_dut%0d", d), out_valid[d], 1);
  endtask

  // in_valid held high; every accept must land exactly WIDTH+2 cycles after the previous.
  task automatic b2b(int d, int n);
    int k, t, last;
    bit upd;
    logic [7:0] m;
    m = 8'((1 << WD[d]) - 1);
    k = 0; t = 0; last = -1; upd = 1'b0;
    @(negedge clk);
    a_in[d] = 8'($urandom) & m; b_in[d] = 8'($urandom) & m; sm[d] = 1'($urandom);
    in_valid[d] = 1'b1;
    while (k < n && t < 400) begin
      if (in_ready[d]) begin
        if (last >= 0) chk($sformatf("spacing_dut%0d", d), cyc - last, WD[d] + 2);
        last = cyc; acc_cyc[d] = cyc;
        push_exp(d, model(WD[d], a_in[d], b_in[d], sm[d] && SEN[d]));
        k++; upd = 1'b1;
      end
      @(negedge clk); t++;
      if (upd) begin
        a_in[d] = 8'($urandom) & m; b_in[d] = 8'($urandom) & m; sm[d] = 1'($urandom);
        upd = 1'b0;
      end
    end
    in_valid[d] = 1'b0;
    chk($sformatf("b2b_accepts_dut%0d", d), k, n);
  endtask

  task automatic rnd(int d, int n);
    for (int i = 0; i < n; i++) issue(d, 8'($urandom), 8'($urandom), 1'($urandom));
    wait_drain(d);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = '1; sm = '0;
    for (int d = 0; d < 3; d++) begin a_in[d] = '0; b_in[d] = '0; acc_cyc[d] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 3'b111);
    chk("rst_out_valid", out_valid, 3'b000);
    chk("rst_busy", busy, 3'b000);
    chk("rst_product", {p2, p1, p0}, 0);

    // Directed products
    issue(0, 8'd7, 8'd5, 1'b0);   wait_drain(0);
    @(negedge clk);
    chk("idle_after_handshake", in_ready[0], 1);
    chk("product_held_0x23", p0, 8'h23);
    issue(0, 8'd8, 8'd8, 1'b1);   wait_drain(0);
    issue(0, 8'd13, 8'd5, 1'b1);  wait_drain(0);
    issue(0, 8'd7, 8'd15, 1'b1);  wait_drain(0);
    issue(0, 8'd15, 8'd15, 1'b0); wait_drain(0);
    issue(1, 8'd15, 8'd15, 1'b1); wait_drain(1);
    issue(1, 8'd13, 8'd5, 1'b1);  wait_drain(1);
    issue(2, 8'd255, 8'd255, 1'b0); wait_drain(2);
    issue(2, 8'd128, 8'd127, 1'b1); wait_drain(2);
    issue(2, 8'd0, 8'd99, 1'b1);    wait_drain(2);

    // Backpressure: held result, ignored in_valid pulses
    out_ready[0] = 1'b0;
    issue(0, 8'd7, 8'd3, 1'b0);
    wait_ov(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid[0], 1);
      chk("bp_in_ready", in_ready[0], 0);
      chk("bp_busy", busy[0], 0);
      chk("bp_product", p0, 8'h15);
      in_valid[0] = (i % 2 == 0); a_in[0] = 8'd1; b_in[0] = 8'd1;
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("bp_release_out_valid", out_valid[0], 0);
    chk("bp_release_in_ready", in_ready[0], 1);
    chk("bp_product_kept", p0, 8'h15);
    chk("bp_single_handshake", qsize(0), 0);

    // Reset during RUN discards the in-flight product
    issue(0, 8'd5, 8'd6, 1'b0);
    @(negedge clk);
    chk("run_busy", busy[0], 1);
    chk("run_in_ready", in_ready[0], 0);
    rst_n = 1'b0;
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready[0], 1);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_product", p0, 8'h00);
    issue(0, 8'd3, 8'd3, 1'b0); wait_drain(0);
    chk("after_rst_product", p0, 8'h09);

    b2b(0, 4); wait_drain(0);
    b2b(1, 4); wait_drain(1);
    b2b(2, 4); wait_drain(2);

    rnd(0, 200);
    rnd(1, 50);
    rnd_bp = 1'b1;
    rnd(2, 1000);
    rnd_bp = 1'b0;
    @(posedge clk); #1;
    out_ready[2] = 1'b1;
    wait_drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
